joystick_link_rx: RTL and testbench

Receive-side endpoint for the joystick command link. It deserialises 16-bit commands sent over a UART line as two 8N1 bytes, high byte first. It validates each command, presents the 10-bit joystick value to the game logic, and returns a one-byte response on TX. The sender transmits its next command only after receiving that response, so this block paces the whole link; it sits on the console side opposite the player controller.

---
 rtl/joystick_link_rx.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_joystick_link_rx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joystick_link_rx.sv
// joystick_link_rx
//
// Console-side endpoint of the joystick command link. Two 8N1 bytes arrive on
// RX, high byte first, and form one 16-bit command. A command whose upper six
// bits are zero carries a 10-bit joystick value, which is published on
// joy_data. Every command, and every high byte left without a low byte, is
// answered with a single RESP_BYTE on TX. The sender only transmits after it
// sees that response, so the response also paces the link. One RESP_BYTE is
// sent after reset to start the sender.
//
// Parameters
//   BAUD_DIV   clocks per bit on RX and TX (must be 8 or more)
//   RESP_BYTE  byte returned on TX
//   TIMEOUT    idle clocks allowed between the high byte and the low byte
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   RX         serial input, idle high, asynchronous to clk
//   TX         serial output, idle high
//   joy_data   last accepted joystick value; holds between updates
//   joy_vld    one-cycle pulse when joy_data updates
//   cmd_err    one-cycle pulse: command upper 6 bits were nonzero
//   frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   timeout    one-cycle pulse: low byte did not arrive in time
//   fsm_state  control FSM state (0 STARTUP, 1 WAIT_HI, 2 WAIT_LO)
//
// Handshake: byte_rdy is a one-cycle strobe with the received byte in
// rx_shift during that cycle. There is no ready: the control FSM accepts a
// byte in every state. A response request is also a one-cycle strobe. It is
// kept in resp_pending until the transmitter is idle and takes it.

module joystick_link_rx #(
    parameter int         BAUD_DIV  = 434,
    parameter logic [7:0] RESP_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 4095
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic [9:0] joy_data,
    output logic       joy_vld,
    output logic       cmd_err,
    output logic       frame_err,
    output logic       timeout,
    output logic [1:0] fsm_state
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_START = 2'd1,
        R_DATA  = 2'd2,
        R_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_START = 2'd1,
        T_DATA  = 2'd2,
        T_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        C_STARTUP = 2'd0,
        C_WAIT_HI = 2'd1,
        C_WAIT_LO = 2'd2
    } ctl_state_t;

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_s1, rx_s2, rx_prev;
    logic rx_fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= RX;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev & ~rx_s2;

    // ------------------------------------------------------------------
    // RX frame FSM
    // ------------------------------------------------------------------
    rx_state_t        rx_state, rx_next;
    logic [CNT_W-1:0] rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_start, rx_sample, rx_stop_ok, rx_stop_bad, rx_idle;
    logic             byte_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= R_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (rx_fall) rx_next = R_START;
            // A line back high at mid start bit is a glitch, not a frame.
            R_START: if (rx_cnt == HALF_LAST) rx_next = rx_s2 ? R_IDLE : R_DATA;
            R_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = R_STOP;
            R_STOP:  if (rx_cnt == BIT_LAST) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        rx_idle     = (rx_state == R_IDLE);
        rx_start    = rx_idle && rx_fall;
        rx_sample   = (rx_state == R_DATA) && (rx_cnt == BIT_LAST);
        rx_stop_ok  = (rx_state == R_STOP) && (rx_cnt == BIT_LAST) && rx_s2;
        rx_stop_bad = (rx_state == R_STOP) && (rx_cnt == BIT_LAST) && !rx_s2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            byte_rdy  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_rdy  <= rx_stop_ok;
            frame_err <= rx_stop_bad;
            // The edge-detect flop adds one clock after the synchroniser, so
            // the bit counter starts at 1 to keep samples centred in each bit.
            if (rx_start) begin
                rx_cnt <= CNT_W'(1);
                rx_bit <= '0;
            end else if ((rx_state != rx_next) || rx_sample) begin
                rx_cnt <= '0;
            end else if (!rx_idle) begin
                rx_cnt <= rx_cnt + CNT_W'(1);
            end
            if (rx_sample) begin
                rx_shift <= {rx_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    ctl_state_t      ctl_state, ctl_next;
    logic [7:0]      hi_byte;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            req_resp, load_hi, cmd_ok, cmd_bad, to_fire;

    // The timeout only advances while no frame is in progress, so a low byte
    // that has already started is never cut off.
    assign to_hit = rx_idle && (to_cnt == TO_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ctl_state <= C_STARTUP;
        else        ctl_state <= ctl_next;
    end

    always_comb begin
        ctl_next = ctl_state;
        case (ctl_state)
            C_STARTUP: ctl_next = C_WAIT_HI;
            C_WAIT_HI: if (byte_rdy) ctl_next = C_WAIT_LO;
            C_WAIT_LO: if (byte_rdy || to_hit) ctl_next = C_WAIT_HI;
            default:   ctl_next = C_STARTUP;
        endcase
    end

    always_comb begin
        req_resp = 1'b0;
        load_hi  = 1'b0;
        cmd_ok   = 1'b0;
        cmd_bad  = 1'b0;
        to_fire  = 1'b0;
        case (ctl_state)
            C_STARTUP: req_resp = 1'b1;
            C_WAIT_HI: load_hi = byte_rdy;
            C_WAIT_LO: begin
                if (byte_rdy) begin
                    req_resp = 1'b1;
                    cmd_ok   = (hi_byte[7:2] == 6'd0);
                    cmd_bad  = (hi_byte[7:2] != 6'd0);
                end else if (to_hit) begin
                    req_resp = 1'b1;
                    to_fire  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_byte  <= '0;
            to_cnt   <= '0;
            joy_data <= '0;
            joy_vld  <= 1'b0;
            cmd_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            joy_vld <= cmd_ok;
            cmd_err <= cmd_bad;
            timeout <= to_fire;
            if (load_hi)      hi_byte <= rx_shift;
            else if (to_fire) hi_byte <= '0;
            if (cmd_ok) joy_data <= {hi_byte[1:0], rx_shift};
            if (load_hi)
                to_cnt <= '0;
            else if ((ctl_state == C_WAIT_LO) && rx_idle && !to_hit)
                to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign fsm_state = ctl_state;

    // ------------------------------------------------------------------
    // Response pending flag: requests made while one is already waiting
    // merge into it, so only one response goes out.
    // ------------------------------------------------------------------
    logic resp_pending;
    logic tx_launch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        resp_pending <= 1'b0;
        else if (tx_launch) resp_pending <= 1'b0;
        else if (req_resp)  resp_pending <= 1'b1;
    end

    // ------------------------------------------------------------------
    // TX frame FSM
    // ------------------------------------------------------------------
    tx_state_t        tx_state, tx_next;
    logic [CNT_W-1:0] tx_cnt;
    logic [2:0]       tx_bit;
    logic [7:0]       tx_shift;
    logic             tx_end, tx_next_bit, tx_to_stop;

    assign tx_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= T_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (resp_pending) tx_next = T_START;
            T_START: if (tx_end) tx_next = T_DATA;
            T_DATA:  if (tx_end && tx_bit == 3'd7) tx_next = T_STOP;
            T_STOP:  if (tx_end) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        tx_launch   = (tx_state == T_IDLE) && resp_pending;
        tx_next_bit = tx_end && ((tx_state == T_START) ||
                                 ((tx_state == T_DATA) && (tx_bit != 3'd7)));
        tx_to_stop  = tx_end && (tx_state == T_DATA) && (tx_bit == 3'd7);
    end

    // TX is driven from a register so the line never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            TX       <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
        end else if (tx_launch) begin
            TX       <= 1'b0;
            tx_shift <= RESP_BYTE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else begin
            if (tx_state != T_IDLE) tx_cnt <= tx_end ? '0 : tx_cnt + CNT_W'(1);
            if (tx_next_bit) begin
                TX       <= tx_shift[0];
                tx_shift <= {1'b0, tx_shift[7:1]};
            end
            if (tx_to_stop) TX <= 1'b1;
            if ((tx_state == T_DATA) && tx_end) tx_bit <= tx_bit + 3'd1;
        end
    end

endmodule

// File: tb/tb_joystick_link_rx.sv
// tb_joystick_link_rx
//
// Drives 8N1 bytes into joystick_link_rx (BAUD_DIV=16, TIMEOUT=400).
// Expected output events (joy_vld / cmd_err / frame_err / timeout together
// with joy_data) are queued in exp_q. Expected TX response bytes are queued in
// resp_q. Two monitors pop and compare these entries when the DUT produces
// them.
`timescale 1ns/1ps

module tb_joystick_link_rx;

    localparam int         BD   = 16;
    localparam int         TO   = 400;
    localparam logic [7:0] RESP = 8'hA5;

    localparam logic [1:0] EV_VLD = 2'd0;
    localparam logic [1:0] EV_CMD = 2'd1;
    localparam logic [1:0] EV_FE  = 2'd2;
    localparam logic [1:0] EV_TO  = 2'd3;

    localparam logic [1:0] S_STARTUP = 2'd0;
    localparam logic [1:0] S_WAIT_HI = 2'd1;
    localparam logic [1:0] S_WAIT_LO = 2'd2;

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       RX    = 1'b1;
    logic       TX;
    logic [9:0] joy_data;
    logic       joy_vld, cmd_err, frame_err, timeout;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    joystick_link_rx #(
        .BAUD_DIV (BD),
        .RESP_BYTE(RESP),
        .TIMEOUT  (TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .TX       (TX),
        .joy_data (joy_data),
        .joy_vld  (joy_vld),
        .cmd_err  (cmd_err),
        .frame_err(frame_err),
        .timeout  (timeout),
        .fsm_state(fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [11:0] exp_q[$];
    logic [7:0]  resp_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor: every output pulse must match the head of exp_q.
    initial forever begin
        @(negedge clk);
        if (rst_n && (joy_vld || cmd_err || frame_err || timeout)) begin
            logic [11:0] act;
            logic [1:0]  ev;
            int          n;
            n = int'(joy_vld) + int'(cmd_err) + int'(frame_err) + int'(timeout);
            if (joy_vld)        ev = EV_VLD;
            else if (cmd_err)   ev = EV_CMD;
            else if (frame_err) ev = EV_FE;
            else                ev = EV_TO;
            act = {ev, joy_data};
            check("event_single_pulse", n, 1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got 0x%0h, expected none", act);
            end else begin
                check("event", act, exp_q.pop_front());
            end
        end
    end

    // TX monitor: decode each 8N1 frame at mid-bit and match against resp_q.
    initial forever begin
        @(negedge clk);
        if (rst_n && TX == 1'b0) begin
            logic [9:0] bits;
            logic       aborted;
            bits    = '1;
            aborted = 1'b0;
            for (int i = 1; i <= 8 + 16 * 9; i++) begin
                @(negedge clk);
                if (!rst_n) begin
                    aborted = 1'b1;
                    break;
                end
                if (i >= 8 && ((i - 8) % 16) == 0) bits[(i - 8) / 16] = TX;
            end
            if (!aborted) begin
                check("tx_start_bit", bits[0], 0);
                check("tx_stop_bit", bits[9], 1);
                if (resp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_response: got 0x%0h, expected none", bits[8:1]);
                end else begin
                    check("tx_byte", bits[8:1], resp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            RX = frame[i];
            repeat (BD - 1) @(negedge clk);
        end
        @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic wait_resp(input string name);
        int n;
        n = 0;
        while (resp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (resp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d responses outstanding after %0d clocks, expected 0", name, resp_q.size(), n);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_tx_start(input string name);
        int n;
        n = 0;
        while (TX !== 1'b0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (TX !== 1'b0) begin
            errors++;
            $display("FAIL %s: TX start bit not seen within %0d clocks, TX=%b", name, n, TX);
        end
    endtask

    // Runs alongside send_byte of a low byte. It counts rising edges from the RX
    // falling edge to joy_vld, then checks that TX starts one edge later.
    task automatic watch_latency;
        int k;
        @(negedge clk);
        k = 0;
        while (k < 300) begin
            @(posedge clk);
            #1;
            k++;
            if (joy_vld) break;
        end
        checks++;
        if (k < 154 || k > 155) begin
            errors++;
            $display("FAIL vld_latency: got %0d clocks, expected 154..155", k);
        end
        @(posedge clk);
        #1;
        check("tx_start_after_vld", TX, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int         mism;
        logic [9:0] startup_frame;
        startup_frame = {1'b1, RESP, 1'b0};

        // 1. reset and startup response
        rst_n = 1'b0;
        RX    = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", TX, 1);
        check("reset_joy_data", joy_data, 0);
        check("reset_pulses", {joy_vld, cmd_err, frame_err, timeout}, 0);
        check("reset_state", fsm_state, S_STARTUP);
        resp_q.push_back(RESP);
        @(negedge clk);
        rst_n = 1'b1;
        mism = 0;
        for (int e = 1; e <= 170; e++) begin
            logic exp_tx;
            @(posedge clk);
            #1;
            if (e >= 2 && e <= 161) exp_tx = startup_frame[(e - 2) / 16];
            else                    exp_tx = 1'b1;
            if (TX !== exp_tx) mism++;
            if (joy_vld || cmd_err || frame_err || timeout) mism++;
        end
        check("startup_wave_mismatches", mism, 0);
        check("state_after_startup", fsm_state, S_WAIT_HI);
        wait_resp("startup_resp");

        // 2. valid commands
        exp_q.push_back({EV_VLD, 10'h3FF});
        resp_q.push_back(RESP);
        send_byte(8'h03);
        fork
            send_byte(8'hFF);
            watch_latency();
        join
        wait_resp("t2a_resp");
        check("t2a_joy_data", joy_data, 10'h3FF);
        exp_q.push_back({EV_VLD, 10'h02A});
        resp_q.push_back(RESP);
        send_byte(8'h00);
        send_byte(8'h2A);
        wait_resp("t2b_resp");

        // 3. command error
        exp_q.push_back({EV_CMD, 10'h02A});
        resp_q.push_back(RESP);
        send_byte(8'h80);
        send_byte(8'h12);
        wait_resp("t3_resp");
        check("t3_state", fsm_state, S_WAIT_HI);
        check("t3_joy_data", joy_data, 10'h02A);

        // 4. timeout, then recovery
        exp_q.push_back({EV_TO, 10'h02A});
        resp_q.push_back(RESP);
        send_byte(8'h01);
        check("t4_state_wait_lo", fsm_state, S_WAIT_LO);
        repeat (450) @(negedge clk);
        wait_resp("t4_timeout_resp");
        check("t4_state_after_timeout", fsm_state, S_WAIT_HI);
        exp_q.push_back({EV_VLD, 10'h055});
        resp_q.push_back(RESP);
        send_byte(8'h00);
        send_byte(8'h55);
        wait_resp("t4_resp");

        // 5. framing error on the low byte
        exp_q.push_back({EV_FE, 10'h055});
        send_byte(8'h01);
        send_byte(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        check("t5_state_wait_lo", fsm_state, S_WAIT_LO);
        check("t5_joy_data_held", joy_data, 10'h055);
        exp_q.push_back({EV_VLD, 10'h110});
        resp_q.push_back(RESP);
        send_byte(8'h10);
        wait_resp("t5_resp");

        // 6a. next high byte starts during the TX stop bit
        exp_q.push_back({EV_VLD, 10'h381});
        resp_q.push_back(RESP);
        send_byte(8'h03);
        fork
            send_byte(8'h81);
            begin
                wait_tx_start("t6_tx_start");
                repeat (146) @(negedge clk);
            end
        join
        check("t6_tx_in_stop", TX, 1);
        exp_q.push_back({EV_VLD, 10'h2C3});
        resp_q.push_back(RESP);
        send_byte(8'h02);
        send_byte(8'hC3);
        wait_resp("t6_overlap_resp");
        check("t6_joy_data", joy_data, 10'h2C3);

        // 6b. 4-clock glitch on RX
        @(negedge clk);
        RX = 1'b0;
        repeat (4) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check("t6_glitch_state", fsm_state, S_WAIT_HI);

        // 6c. reset in the middle of a response
        exp_q.push_back({EV_VLD, 10'h0F0});
        resp_q.push_back(RESP);
        send_byte(8'h00);
        send_byte(8'hF0);
        wait_tx_start("t6_reset_tx_start");
        repeat (50) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_tx", TX, 1);
        check("midreset_joy_data", joy_data, 0);
        check("midreset_state", fsm_state, S_STARTUP);
        check("midreset_pulses", {joy_vld, cmd_err, frame_err, timeout}, 0);
        resp_q.delete();
        repeat (5) @(negedge clk);
        resp_q.push_back(RESP);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("restart_edge1_tx", TX, 1);
        @(posedge clk);
        #1;
        check("restart_edge2_tx", TX, 0);
        wait_resp("restart_resp");

        check("exp_q_empty", exp_q.size(), 0);
        check("resp_q_empty", resp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
